// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler: FSM state encoding,
// accumulator width and the default 8 kHz sample divider for a 50 MHz clock.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT,
    ISSUE
  } sched_state_e;

  // 18 bits holds the sum of four full-scale signed 16-bit voices without wrap.
  localparam int ACC_W              = 18;
  localparam int DEFAULT_SAMPLE_DIV = 6250;

endpackage

// File: rtl/dac_sched_tick.sv
// Free-running sample-rate divider: counts 0..SAMPLE_DIV-1 and flags the
// terminal count as a one-cycle tick.
module dac_sched_tick
  import dac_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic CLOCK_50,
  input  logic iRST_N,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) count_q <= '0;
    else         count_q <= count_d;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/dac_sample_scheduler.sv
// Per-tick voice polling and mixing into a single DAC sample.
// Define DAC_SCHED_SAT_EN to clamp the mix to 16-bit range instead of wrapping.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int NVOICE     = 4,
  parameter int VTIMEOUT   = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 iRST_N,
  input  logic [NVOICE-1:0]    voice_en,
  output logic [NVOICE-1:0]    voice_rd,
  input  logic [NVOICE-1:0]    voice_vld,
  input  logic [16*NVOICE-1:0] voice_sample,
  input  logic                 dac_busy,
  output logic [15:0]          dac_sample,
  output logic                 dac_go,
  input  logic                 err_clr,
  output logic                 overrun,
  output logic                 timeout
);

  // idx must reach NVOICE so "past the last voice" is representable.
  localparam int IDX_W = $clog2(NVOICE + 1);
  localparam int TO_W  = (VTIMEOUT > 1) ? $clog2(VTIMEOUT) : 1;

  logic tick;

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NVOICE-1:0]        en_q, en_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [TO_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [NVOICE-1:0]        voice_rd_q, voice_rd_d;
  logic [15:0]              dac_sample_q, dac_sample_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_q, timeout_d;

  logic                     cur_en, cur_vld, rem_any;
  logic [15:0]              cur_sample;
  logic [NVOICE-1:0]        idx_onehot;
  logic [15:0]              mixed;

  dac_sched_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .tick     (tick)
  );

  // Select the current voice; rem_any tells SCAN whether any enabled voice is left.
  always_comb begin
    cur_en     = 1'b0;
    cur_vld    = 1'b0;
    cur_sample = '0;
    rem_any    = 1'b0;
    idx_onehot = '0;
    for (int i = 0; i < NVOICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_en        = en_q[i];
        cur_vld       = voice_vld[i];
        cur_sample    = voice_sample[16*i +: 16];
        idx_onehot[i] = 1'b1;
      end
      if ((IDX_W'(i) >= idx_q) && en_q[i]) rem_any = 1'b1;
    end
  end

`ifdef DAC_SCHED_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  always_comb begin
    if (acc_q > SAT_MAX)      mixed = 16'h7FFF;
    else if (acc_q < SAT_MIN) mixed = 16'h8000;
    else                      mixed = acc_q[15:0];
  end
`else
  always_comb begin
    mixed = acc_q[15:0];
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    en_d         = en_q;
    acc_d        = acc_q;
    wait_cnt_d   = wait_cnt_q;
    voice_rd_d   = '0;
    dac_sample_d = dac_sample_q;
    overrun_d    = overrun_q & ~err_clr;
    timeout_d    = timeout_q & ~err_clr;

    // A tick is only consumed from IDLE; anywhere else it is lost.
    if (tick && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          en_d    = voice_en;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      SCAN: begin
        if (cur_en) begin
          state_d    = REQ;
          voice_rd_d = idx_onehot;
          wait_cnt_d = '0;
        end else if (!rem_any) begin
          state_d      = ISSUE;
          dac_sample_d = mixed;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (cur_vld) begin
          acc_d   = acc_q + {{(ACC_W-16){cur_sample[15]}}, cur_sample};
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end else if (wait_cnt_q == TO_W'(VTIMEOUT - 1)) begin
          timeout_d = 1'b1;
          idx_d     = idx_q + IDX_W'(1);
          state_d   = SCAN;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ISSUE: begin
        if (!dac_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      en_q         <= '0;
      acc_q        <= '0;
      wait_cnt_q   <= '0;
      voice_rd_q   <= '0;
      dac_sample_q <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      en_q         <= en_d;
      acc_q        <= acc_d;
      wait_cnt_q   <= wait_cnt_d;
      voice_rd_q   <= voice_rd_d;
      dac_sample_q <= dac_sample_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // dac_sample is already stable for the whole ISSUE stay; go fires on the first non-busy cycle.
  assign dac_go     = (state_q == ISSUE) && !dac_busy;
  assign voice_rd   = voice_rd_q;
  assign dac_sample = dac_sample_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed testbench for dac_sample_scheduler (SAMPLE_DIV=100, NVOICE=4, VTIMEOUT=8).
// Cycle n is the n-th clock period after reset release; the first tick lands in cycle 99.
module tb_dac_sample_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        iRST_N;
  logic [3:0]  voice_en;
  logic [3:0]  voice_rd;
  logic [3:0]  voice_vld;
  logic [63:0] voice_sample;
  logic        dac_busy;
  logic [15:0] dac_sample;
  logic        dac_go;
  logic        err_clr;
  logic        overrun;
  logic        timeout;

  logic [3:0]  resp_mask;
  logic [3:0]  noise_mask;
  logic [3:0]  rd_seen;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  dac_sample_scheduler #(.SAMPLE_DIV(100), .NVOICE(4), .VTIMEOUT(8)) dut (
    .CLOCK_50     (CLOCK_50),
    .iRST_N       (iRST_N),
    .voice_en     (voice_en),
    .voice_rd     (voice_rd),
    .voice_vld    (voice_vld),
    .voice_sample (voice_sample),
    .dac_busy     (dac_busy),
    .dac_sample   (dac_sample),
    .dac_go       (dac_go),
    .err_clr      (err_clr),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Voice model: a requested voice answers with vld one cycle after its rd pulse.
  always begin
    @(negedge CLOCK_50);
    rd_seen = voice_rd & resp_mask;
    @(posedge CLOCK_50);
    #1;
    voice_vld = rd_seen | noise_mask;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_samples(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3);
    voice_sample = {s3, s2, s1, s0};
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    iRST_N = 1'b1;
  endtask

  task automatic skip_to(input int target);
    while (cyc < target) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Runs until the first dac_go or until cycle limit; leaves the bench at the start of the next cycle.
  task automatic wait_go(input int limit, output int go_cyc, output logic [15:0] samp,
                         output int rd_cnt, output bit oh_ok);
    go_cyc = -1;
    samp   = 'x;
    rd_cnt = 0;
    oh_ok  = 1'b1;
    while (go_cyc < 0 && cyc <= limit) begin
      @(negedge CLOCK_50);
      if (voice_rd != 4'b0) begin
        rd_cnt++;
        if (!$onehot(voice_rd)) oh_ok = 1'b0;
      end
      if (dac_go) begin
        go_cyc = cyc;
        samp   = dac_sample;
      end
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic test_reset();
    voice_en = 4'b1111; dac_busy = 1'b0; err_clr = 1'b0;
    resp_mask = 4'b1111; noise_mask = 4'b0000; voice_vld = 4'b0000;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    iRST_N = 1'b0;
    @(posedge CLOCK_50);
    #1;
    n_checks++; if (voice_rd !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_voice_rd: got %b expected 0000", voice_rd); end
    n_checks++; if (dac_go !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dac_go: got %b expected 0", dac_go); end
    n_checks++; if (dac_sample !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_dac_sample: got %0d expected 0", dac_sample); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    do_reset();
    skip_to(50);
    @(negedge CLOCK_50);
    n_checks++; if (dac_go !== 1'b0 || voice_rd !== 4'b0) begin n_fail++; $display("[TB] FAIL pre_tick_idle: got go=%b rd=%b expected 0/0000", dac_go, voice_rd); end
  endtask

  task automatic test_mix_all();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    do_reset();
    voice_en = 4'b1111; resp_mask = 4'b1111; noise_mask = 4'b0000;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 113) begin n_fail++; $display("[TB] FAIL mix_all_latency: got cycle %0d expected 113", go_cyc); end
    n_checks++; if (samp !== 16'd257) begin n_fail++; $display("[TB] FAIL mix_all_sample: got %0d expected 257", $signed(samp)); end
    n_checks++; if (rd_cnt !== 4 || !oh_ok) begin n_fail++; $display("[TB] FAIL mix_all_rd: got %0d pulses onehot=%0d expected 4 onehot=1", rd_cnt, oh_ok); end
    @(negedge CLOCK_50);
    n_checks++; if (dac_go !== 1'b0) begin n_fail++; $display("[TB] FAIL go_width: got %b expected 0", dac_go); end
  endtask

  task automatic test_back_to_back();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    set_samples(16'd1, 16'd2, 16'd3, 16'd4);
    wait_go(300, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 213) begin n_fail++; $display("[TB] FAIL b2b_latency: got cycle %0d expected 213", go_cyc); end
    n_checks++; if (samp !== 16'd10) begin n_fail++; $display("[TB] FAIL b2b_sample: got %0d expected 10", $signed(samp)); end
  endtask

  task automatic test_partial_enable();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    do_reset();
    voice_en = 4'b0101; resp_mask = 4'b1111;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 108) begin n_fail++; $display("[TB] FAIL en0101_latency: got cycle %0d expected 108", go_cyc); end
    n_checks++; if (samp !== 16'd300 || rd_cnt !== 2) begin n_fail++; $display("[TB] FAIL en0101_result: got sample %0d rd %0d expected 300 rd 2", $signed(samp), rd_cnt); end
    voice_en = 4'b1000;
    wait_go(300, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 207) begin n_fail++; $display("[TB] FAIL en1000_latency: got cycle %0d expected 207", go_cyc); end
    n_checks++; if (samp !== 16'd7 || rd_cnt !== 1) begin n_fail++; $display("[TB] FAIL en1000_result: got sample %0d rd %0d expected 7 rd 1", $signed(samp), rd_cnt); end
  endtask

  task automatic test_saturation();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    logic [15:0] exp_pos, exp_neg;
`ifdef DAC_SCHED_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'hFA00;
    exp_neg = 16'hC780;
`endif
    do_reset();
    voice_en = 4'b1111; resp_mask = 4'b1111;
    set_samples(16'd16000, 16'd16000, 16'd16000, 16'd16000);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 113 || samp !== exp_pos) begin n_fail++; $display("[TB] FAIL sat_pos: got cycle %0d sample %h expected 113 %h", go_cyc, samp, exp_pos); end
    set_samples(-16'sd20000, -16'sd20000, -16'sd20000, -16'sd20000);
    wait_go(300, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 213 || samp !== exp_neg) begin n_fail++; $display("[TB] FAIL sat_neg: got cycle %0d sample %h expected 213 %h", go_cyc, samp, exp_neg); end
  endtask

  task automatic test_timeout();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    do_reset();
    voice_en = 4'b1111; resp_mask = 4'b1011; noise_mask = 4'b1010;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 120) begin n_fail++; $display("[TB] FAIL timeout_latency: got cycle %0d expected 120", go_cyc); end
    n_checks++; if (samp !== 16'd57) begin n_fail++; $display("[TB] FAIL timeout_sample: got %0d expected 57", $signed(samp)); end
    n_checks++; if (timeout !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_flag: got timeout=%b overrun=%b expected 1/0", timeout, overrun); end
    resp_mask = 4'b1111; noise_mask = 4'b0000;
    err_clr = 1'b1;
    @(posedge CLOCK_50);
    #1;
    err_clr = 1'b0;
    @(negedge CLOCK_50);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeout); end
  endtask

  task automatic test_overrun();
    int go_cnt = 0;
    int go_at  = -1;
    logic [15:0] go_samp = 'x;
    do_reset();
    voice_en = 4'b0000;
    while (cyc <= 298) begin
      dac_busy = (cyc >= 60 && cyc < 210);
      err_clr  = (cyc == 199 || cyc == 250);
      @(negedge CLOCK_50);
      if (dac_go) begin
        go_cnt++;
        go_at   = cyc;
        go_samp = dac_sample;
      end
      if (cyc == 198) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL overrun_before_drop: got %b expected 0", overrun); end
      end
      if (cyc == 200) begin
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_set_wins: got %b expected 1", overrun); end
      end
      if (cyc == 251) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun); end
      end
      @(posedge CLOCK_50);
      #1;
    end
    dac_busy = 1'b0;
    err_clr  = 1'b0;
    n_checks++; if (go_cnt !== 1 || go_at !== 210) begin n_fail++; $display("[TB] FAIL busy_single_go: got %0d pulses at cycle %0d expected 1 at 210", go_cnt, go_at); end
    n_checks++; if (go_samp !== 16'd0) begin n_fail++; $display("[TB] FAIL busy_sample: got %0d expected 0", $signed(go_samp)); end
  endtask

  task automatic test_all_disabled();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    do_reset();
    voice_en = 4'b1111; resp_mask = 4'b1111;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    voice_en = 4'b0000;
    wait_go(300, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 201) begin n_fail++; $display("[TB] FAIL disabled_latency: got cycle %0d expected 201", go_cyc); end
    n_checks++; if (samp !== 16'd0) begin n_fail++; $display("[TB] FAIL disabled_sample: got %0d expected 0", $signed(samp)); end
    n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("[TB] FAIL disabled_rd: got %0d pulses expected 0", rd_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    int go_cyc; logic [15:0] samp; int rd_cnt; bit oh_ok;
    do_reset();
    voice_en = 4'b1111; resp_mask = 4'b1111;
    set_samples(16'd100, -16'sd50, 16'd200, 16'd7);
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 113 || samp !== 16'd257) begin n_fail++; $display("[TB] FAIL pre_reset_txn: got cycle %0d sample %0d expected 113 257", go_cyc, $signed(samp)); end
    resp_mask = 4'b0000;
    skip_to(203);
    iRST_N = 1'b0;
    #1;
    n_checks++; if (dac_sample !== 16'd0) begin n_fail++; $display("[TB] FAIL midreset_dac_sample: got %0d expected 0", dac_sample); end
    n_checks++; if (voice_rd !== 4'b0 || dac_go !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_strobes: got rd=%b go=%b expected 0000/0", voice_rd, dac_go); end
    n_checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_flags: got overrun=%b timeout=%b expected 0/0", overrun, timeout); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    resp_mask = 4'b1111;
    iRST_N = 1'b1;
    wait_go(200, go_cyc, samp, rd_cnt, oh_ok);
    n_checks++; if (go_cyc !== 113) begin n_fail++; $display("[TB] FAIL resume_latency: got cycle %0d expected 113", go_cyc); end
    n_checks++; if (samp !== 16'd257) begin n_fail++; $display("[TB] FAIL resume_sample: got %0d expected 257", $signed(samp)); end
  endtask

  initial begin
    test_reset();
    test_mix_all();
    test_back_to_back();
    test_partial_enable();
    test_saturation();
    test_timeout();
    test_overrun();
    test_all_disabled();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 6250, meaning CLOCK_50 cycles per sample tick (8 kHz).
REQ-002 SHALL have parameter NVOICE, default 4, meaning the number of voice requesters (range 1..4).
REQ-003 SHALL have parameter VTIMEOUT, default 8, meaning the cycles allowed per voice response.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: system clock, 50 MHz.
REQ-005 SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port voice_en, input, NVOICE bits: per-voice enable.
REQ-007 SHALL have port voice_rd, output, NVOICE bits: one-hot, one-cycle sample request.
REQ-008 SHALL have port voice_vld, input, NVOICE bits: per-voice sample valid.
REQ-009 SHALL have port voice_sample, input, 16*NVOICE bits: signed samples, voice i at [16i+15:16i].
REQ-010 SHALL have port dac_busy, input, 1 bit: high while the DAC controller is mid-transfer.
REQ-011 SHALL have port dac_sample, output, 16 bits: signed mixed sample to the DAC controller.
REQ-012 SHALL have port dac_go, output, 1 bit: one-cycle strobe marking dac_sample as new.
REQ-013 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, a tick was dropped.
REQ-015 SHALL have port timeout, output, 1 bit: sticky flag, a voice failed to respond.

Function
REQ-016 SHALL count 0..SAMPLE_DIV-1 with a free-running divider and raise an internal tick on the cycle where count == SAMPLE_DIV-1.
REQ-017 SHALL use FSM states IDLE, SCAN, REQ, WAIT, ISSUE.
REQ-018 IDLE + tick SHALL go to SCAN, latch voice_en, and clear idx and the 18-bit accumulator.
REQ-019 SCAN SHALL go to REQ when the latched enable[idx] is set, else advance idx; after the last voice it SHALL go to ISSUE; each skipped voice costs 1 cycle.
REQ-020 REQ SHALL assert voice_rd[idx] for exactly 1 cycle, then go to WAIT.
REQ-021 WAIT SHALL add sign-extended voice_sample[idx] to the accumulator on voice_vld[idx], then advance idx and return to SCAN.
REQ-022 WAIT SHALL also return to SCAN after VTIMEOUT cycles without voice_vld[idx], add 0, and set timeout.
REQ-023 SHALL ignore voice_vld on any bit other than idx.
REQ-024 ISSUE SHALL hold while dac_busy=1.
REQ-025 ISSUE with dac_busy=0 SHALL register dac_sample and pulse dac_go for 1 cycle in the same cycle, then go to IDLE.
REQ-026 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun; the divider SHALL keep running.
REQ-027 When all voices are disabled, the block SHALL still issue dac_sample = 0.
REQ-028 err_clr SHALL clear both flags; if err_clr and a set event occur in the same cycle, the set SHALL win.
REQ-029 Latency from tick with all voices ready in 1 cycle and dac_busy=0 SHALL be 3*NVOICE+2 cycles to dac_go.

Reset
REQ-030 On reset: FSM IDLE, divider 0, idx 0, accumulator 0, voice_rd 0, dac_go 0, dac_sample 0, overrun 0, timeout 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without issuing dac_go.

Configuration
REQ-032 With DAC_SCHED_SAT_EN defined, the accumulator SHALL be clamped to [-32768, 32767] before driving dac_sample.
REQ-033 Without DAC_SCHED_SAT_EN, dac_sample SHALL be accumulator[15:0] (two's-complement wrap).

Structure
REQ-034 Package dac_sched_pkg SHALL hold the FSM state enum, the 18-bit accumulator width constant and the default SAMPLE_DIV.
REQ-035 Sub-module dac_sched_tick (the divider and tick generator) SHALL be the only sub-module.

Verification
REQ-036 Scenario: NVOICE=4, all enabled, samples 100, -50, 200, 7, vld 1 cycle after rd, SAMPLE_DIV=100 -> dac_go at tick+14, dac_sample=257.
REQ-037 Scenario: four samples of 16000 -> with SAT_EN dac_sample=32767; without SAT_EN dac_sample=64000 mod 65536 = -1536.
REQ-038 Scenario: voice 2 never asserts vld -> timeout=1 after 8 cycles, its sample treated as 0, dac_go still fires; err_clr -> timeout=0.
REQ-039 Scenario: dac_busy held high for 150 cycles with SAMPLE_DIV=100 -> overrun=1, exactly one dac_go after dac_busy falls.
REQ-040 Scenario: voice_en=0000 -> dac_go at tick+2 with dac_sample=0, voice_rd never asserted.
REQ-041 Scenario: iRST_N asserted during WAIT -> all outputs 0 immediately, no dac_go, normal operation resumes at the next tick.
